pc_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the pipelined RV32I core. It owns the PC register, issues instruction-memory requests, and holds the IF/ID instruction register with a one-entry skid buffer.
- It applies EX-stage redirects (branch taken, jal, jalr) using the target from the branch-PC unit, and generates the pipeline flushes.
- It raises a trap on a misaligned redirect target.

---
 rtl/pc_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: PC register, imem request, IF/ID register with skid.
// Applies EX redirects, raises flushes, and traps misaligned redirect targets.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_pc,
  input  logic [31:0]      ex_pc,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic             if_valid,
  output logic [31:0]      if_inst,
  output logic [31:0]      if_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             trap,
  output logic [31:0]      trap_epc,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_SKID,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_pc;
  logic [31:0] r_redir_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;

  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;

  logic        r_trap;
  logic [31:0] r_trap_epc;
  logic [CNT_W-1:0] r_cnt;

  logic        w_req;
  logic        w_redirect;
  logic        w_misal;
  logic [31:0] w_tgt;
  logic        w_accept;
  logic        w_wait;
  logic [31:0] w_pc_inc;

  assign w_redirect = ex_valid &
                      (ex_is_jal | ex_is_jalr |
                       (ex_is_branch & ex_br_taken));
  assign w_misal    = (ex_br_pc[1:0] != 2'b00);
  assign w_tgt      = w_misal ? TRAP_VEC : ex_br_pc;
  assign w_accept   = w_req & imem_ready;
  assign w_pc_inc   = r_pc + 32'd4;

  // A request in flight that memory has not answered must be drained
  // before the redirect target can be issued.
  assign w_wait = w_req & ~imem_ready &
                  ((r_state == S_FETCH) | (r_state == S_DRAIN));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a redirect overrides every other transition
  always_comb begin
    w_next = r_state;
    if (w_redirect) begin
      w_next = w_wait ? S_DRAIN : S_FETCH;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_next = S_FETCH;
        end
        S_FETCH: begin
          if (w_accept && stall) begin
            w_next = S_SKID;
          end
        end
        S_SKID: begin
          if (!stall) begin
            w_next = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            w_next = S_FETCH;
          end
        end
        default: begin
          w_next = S_BOOT;
        end
      endcase
    end
  end

  // Request outputs; pc is held during DRAIN so it is also the drain address
  always_comb begin
    w_req      = 1'b0;
    imem_addr  = r_pc;
    flush_ifid = w_redirect;
    flush_idex = w_redirect;
    case (r_state)
      S_FETCH: w_req = 1'b1;
      S_DRAIN: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    imem_req = w_req;
  end

  // PC and pending-redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_redir_pc <= RESET_PC;
    end else if (w_redirect) begin
      if (w_wait) begin
        r_redir_pc <= w_tgt;
      end else begin
        r_pc <= w_tgt;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            r_pc <= w_pc_inc;
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            r_pc <= r_redir_pc;
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // Skid buffer captures a word accepted while IF/ID is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_inst <= NOP;
      r_skid_pc   <= 32'h0;
    end else if ((r_state == S_FETCH) && w_accept && stall) begin
      r_skid_inst <= imem_rdata;
      r_skid_pc   <= r_pc;
    end
  end

  // IF/ID register: load on accept or skid release, bubble on a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP;
      r_if_pc    <= 32'h0;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!stall) begin
            if (w_accept) begin
              r_if_valid <= 1'b1;
              r_if_inst  <= imem_rdata;
              r_if_pc    <= r_pc;
            end else begin
              r_if_valid <= 1'b0;
            end
          end
        end
        S_SKID: begin
          if (!stall) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= r_skid_inst;
            r_if_pc    <= r_skid_pc;
          end
        end
        S_DRAIN: begin
          r_if_valid <= 1'b0;
        end
        default: begin
          r_if_valid <= r_if_valid;
        end
      endcase
    end
  end

  // Misaligned-target trap pulse, one cycle after the redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap     <= 1'b0;
      r_trap_epc <= 32'h0;
    end else begin
      r_trap <= w_redirect & w_misal;
      if (w_redirect && w_misal) begin
        r_trap_epc <= ex_pc;
      end
    end
  end

  // Applied-redirect counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_redirect) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign if_valid     = r_if_valid;
  assign if_inst      = r_if_inst;
  assign if_pc        = r_if_pc;
  assign trap         = r_trap;
  assign trap_epc     = r_trap_epc;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed table-driven bench for pc_fetch_ctrl.
// Each row is one clock cycle: inputs plus outputs expected in that cycle.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_br_pc = 32'h0;
  logic [31:0] ex_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        trap;
  logic [31:0] trap_epc;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .ex_br_taken  (ex_br_taken),
    .ex_br_pc     (ex_br_pc),
    .ex_pc        (ex_pc),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .trap         (trap),
    .trap_epc     (trap_epc),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, exv, br, jal, jalr, tk;
    logic [31:0] brpc, expc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifpc;
    logic        fl, trap;
    logic [31:0] epc, cnt;
  } vec_t;

  vec_t v[29];

  function automatic vec_t mk(
    input logic stall, exv, br, jal, jalr, tk,
    input logic [31:0] brpc, expc,
    input logic rdy, req,
    input logic [31:0] addr,
    input logic ifv,
    input logic [31:0] ifpc,
    input logic fl, trp,
    input logic [31:0] epc, cnt);
    vec_t r;
    r.stall = stall; r.exv = exv; r.br = br;
    r.jal = jal; r.jalr = jalr; r.tk = tk;
    r.brpc = brpc; r.expc = expc; r.rdy = rdy;
    r.req = req; r.addr = addr; r.ifv = ifv;
    r.ifpc = ifpc; r.fl = fl; r.trap = trp;
    r.epc = epc; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", nm, idx, act, exp);
    end
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0;
    ex_is_jalr = 0; ex_br_taken = 0;
  endtask

  initial begin
    //          st ev br jl jr tk brpc   expc   rdy req addr   ifv ifpc   fl tr epc    cnt
    v[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0);
    v[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0);
    v[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h4,   1, 32'h0,   0, 0, 32'h0,  0);
    v[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1, 32'h8,   1, 32'h4,   0, 0, 32'h0,  0);
    v[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1, 32'h8,   0, 32'h4,   0, 0, 32'h0,  0);
    v[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1, 32'h8,   0, 32'h4,   0, 0, 32'h0,  0);
    v[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h8,   0, 32'h4,   0, 0, 32'h0,  0);
    v[7]  = mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'hC,   1, 32'h8,   0, 0, 32'h0,  0);
    v[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 0, 32'h10,  1, 32'h8,   0, 0, 32'h0,  0);
    v[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 0, 32'h10,  1, 32'h8,   0, 0, 32'h0,  0);
    v[10] = mk(0, 1, 1, 0, 0, 1, 32'h40,  32'h30, 1, 1, 32'h10,  1, 32'hC,   1, 0, 32'h0,  0);
    v[11] = mk(0, 1, 1, 0, 0, 0, 32'h40,  32'h30, 1, 1, 32'h40,  0, 32'hC,   0, 0, 32'h0,  1);
    v[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h44,  1, 32'h40,  0, 0, 32'h0,  1);
    v[13] = mk(1, 1, 0, 1, 0, 0, 32'h80,  32'h34, 0, 1, 32'h48,  1, 32'h44,  1, 0, 32'h0,  1);
    v[14] = mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1, 32'h48,  0, 32'h44,  0, 0, 32'h0,  2);
    v[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 1, 32'h48,  0, 32'h44,  0, 0, 32'h0,  2);
    v[16] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h48,  0, 32'h44,  0, 0, 32'h0,  2);
    v[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h80,  0, 32'h44,  0, 0, 32'h0,  2);
    v[18] = mk(0, 1, 0, 1, 0, 0, 32'h42,  32'h20, 1, 1, 32'h84,  1, 32'h80,  1, 0, 32'h0,  2);
    v[19] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h100, 0, 32'h80,  0, 1, 32'h20, 3);
    v[20] = mk(0, 1, 0, 0, 1, 0, 32'h200, 32'h24, 0, 1, 32'h104, 1, 32'h100, 1, 0, 32'h20, 3);
    v[21] = mk(0, 1, 0, 0, 1, 0, 32'h300, 32'h28, 0, 1, 32'h104, 0, 32'h100, 1, 0, 32'h20, 4);
    v[22] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h104, 0, 32'h100, 0, 0, 32'h20, 5);
    v[23] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h300, 0, 32'h100, 0, 0, 32'h20, 5);
    v[24] = mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h304, 1, 32'h300, 0, 0, 32'h20, 5);
    v[25] = mk(1, 1, 1, 0, 0, 1, 32'h500, 32'h2C, 1, 0, 32'h308, 1, 32'h300, 1, 0, 32'h20, 5);
    v[26] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h500, 0, 32'h300, 0, 0, 32'h20, 6);
    v[27] = mk(0, 0, 0, 1, 0, 0, 32'h600, 32'h0,  1, 1, 32'h504, 1, 32'h500, 0, 0, 32'h20, 6);
    v[28] = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  1, 1, 32'h508, 1, 32'h504, 0, 0, 32'h20, 6);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", -1, {31'h0, imem_req}, 32'h0);
    chk("rst_addr", -1, imem_addr, 32'h0);
    chk("rst_ifv", -1, {31'h0, if_valid}, 32'h0);
    chk("rst_inst", -1, if_inst, 32'h0000_0013);
    chk("rst_ifpc", -1, if_pc, 32'h0);
    chk("rst_trap", -1, {31'h0, trap}, 32'h0);
    chk("rst_epc", -1, trap_epc, 32'h0);
    chk("rst_cnt", -1, redirect_cnt, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      stall        = v[i].stall;
      ex_valid     = v[i].exv;
      ex_is_branch = v[i].br;
      ex_is_jal    = v[i].jal;
      ex_is_jalr   = v[i].jalr;
      ex_br_taken  = v[i].tk;
      ex_br_pc     = v[i].brpc;
      ex_pc        = v[i].expc;
      imem_ready   = v[i].rdy;
      imem_rdata   = 32'hC000_0000 | v[i].addr;
      #1;
      chk("req", i, {31'h0, imem_req}, {31'h0, v[i].req});
      if (v[i].req) chk("addr", i, imem_addr, v[i].addr);
      chk("if_valid", i, {31'h0, if_valid}, {31'h0, v[i].ifv});
      chk("if_pc", i, if_pc, v[i].ifpc);
      if (v[i].ifv) chk("if_inst", i, if_inst, 32'hC000_0000 | v[i].ifpc);
      chk("flush_ifid", i, {31'h0, flush_ifid}, {31'h0, v[i].fl});
      chk("flush_idex", i, {31'h0, flush_idex}, {31'h0, v[i].fl});
      chk("trap", i, {31'h0, trap}, {31'h0, v[i].trap});
      chk("trap_epc", i, trap_epc, v[i].epc);
      chk("cnt", i, redirect_cnt, v[i].cnt);
      @(negedge clk);
    end

    // Enter DRAIN, then assert reset asynchronously mid-cycle
    clr_ex();
    stall = 0;
    ex_valid = 1; ex_is_jal = 1;
    ex_br_pc = 32'h700; ex_pc = 32'h40;
    imem_ready = 0;
    @(negedge clk);
    clr_ex();
    #1;
    chk("drain_req", 100, {31'h0, imem_req}, 32'h1);
    chk("drain_addr", 100, imem_addr, 32'h50C);
    chk("drain_cnt", 100, redirect_cnt, 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 101, {31'h0, imem_req}, 32'h0);
    chk("arst_addr", 101, imem_addr, 32'h0);
    chk("arst_cnt", 101, redirect_cnt, 32'h0);
    chk("arst_ifv", 101, {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1;
    #1;
    chk("boot_req", 102, {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("fetch_req", 103, {31'h0, imem_req}, 32'h1);
    chk("fetch_addr", 103, imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
